// File: rtl/traffic_monitor_if.sv
// Lamp-line and status bundle between the traffic_light driver side (master) and traffic_monitor (slave).
// o_cycle_cnt is present only when TRAFFIC_MON_CYCLE_CNT_EN is defined.
interface traffic_monitor_if #(
  parameter int CNT_W = 8
);
  logic             i_ns_red;
  logic             i_ns_yellow;
  logic             i_ns_green;
  logic             i_ew_red;
  logic             i_ew_yellow;
  logic             i_ew_green;
  logic             i_fault_clr;
  logic [1:0]       o_phase;
  logic             o_phase_vld;
  logic             o_fault;
  logic [2:0]       o_fault_code;
  logic             o_force_flash;
  logic [CNT_W-1:0] o_dwell;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  logic [15:0]      o_cycle_cnt;

  modport master (
    output i_ns_red, i_ns_yellow, i_ns_green, i_ew_red, i_ew_yellow, i_ew_green, i_fault_clr,
    input  o_phase, o_phase_vld, o_fault, o_fault_code, o_force_flash, o_dwell, o_cycle_cnt
  );
  modport slave (
    input  i_ns_red, i_ns_yellow, i_ns_green, i_ew_red, i_ew_yellow, i_ew_green, i_fault_clr,
    output o_phase, o_phase_vld, o_fault, o_fault_code, o_force_flash, o_dwell, o_cycle_cnt
  );
`else
  modport master (
    output i_ns_red, i_ns_yellow, i_ns_green, i_ew_red, i_ew_yellow, i_ew_green, i_fault_clr,
    input  o_phase, o_phase_vld, o_fault, o_fault_code, o_force_flash, o_dwell
  );
  modport slave (
    input  i_ns_red, i_ns_yellow, i_ns_green, i_ew_red, i_ew_yellow, i_ew_green, i_fault_clr,
    output o_phase, o_phase_vld, o_fault, o_fault_code, o_force_flash, o_dwell
  );
`endif
endinterface

// File: rtl/traffic_monitor.sv
// Lamp-side conflict monitor: decodes lamps into a phase, checks encoding/order/dwell, latches a fault.
// Optional completed-cycle counter enabled by TRAFFIC_MON_CYCLE_CNT_EN.
module traffic_monitor #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 16,
  parameter int MIN_YELLOW = 3,
  parameter int MAX_YELLOW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  traffic_monitor_if.slave mon
);
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;

  localparam logic [1:0]       PH_EW_Y    = 2'd3;
  localparam logic [2:0]       FC_NONE    = 3'd0;
  localparam logic [2:0]       FC_COMBO   = 3'd1;
  localparam logic [2:0]       FC_ORDER   = 3'd2;
  localparam logic [2:0]       FC_SHORT_G = 3'd3;
  localparam logic [2:0]       FC_SHORT_Y = 3'd4;
  localparam logic [2:0]       FC_Y_TMO   = 3'd5;
  localparam logic [CNT_W:0]   MIN_G_W    = MIN_GREEN[CNT_W:0];
  localparam logic [CNT_W:0]   MIN_Y_W    = MIN_YELLOW[CNT_W:0];
  localparam logic [CNT_W-1:0] MAX_Y_W    = MAX_YELLOW[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DWELL_MAX  = {CNT_W{1'b1}};

  // Lamp vector order {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}; returns {legal, phase}.
  function automatic logic [2:0] decode_lamps(input logic [5:0] l);
    case (l)
      6'b001100: decode_lamps = 3'b100;
      6'b010100: decode_lamps = 3'b101;
      6'b100001: decode_lamps = 3'b110;
      6'b100010: decode_lamps = 3'b111;
      default:   decode_lamps = 3'b000;
    endcase
  endfunction

  logic [5:0]       lamp_q;
  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             vld_q, vld_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             first_q, first_d;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  logic [15:0]      cycle_cnt_q, cycle_cnt_d;
`endif

  logic [2:0]       dec_s;
  logic             legal_s;
  logic [1:0]       lamp_ph_s;
  logic [1:0]       next_ph_s;
  logic             change_s;
  logic [CNT_W:0]   dwell_p1_s;
  logic [CNT_W-1:0] dwell_sat_s;
  logic [2:0]       run_code_s;

  assign dec_s       = decode_lamps(lamp_q);
  assign legal_s     = dec_s[2];
  assign lamp_ph_s   = dec_s[1:0];
  assign next_ph_s   = phase_q + 2'd1;
  assign change_s    = (lamp_ph_s != phase_q);
  assign dwell_p1_s  = {1'b0, dwell_q} + {{CNT_W{1'b0}}, 1'b1};
  assign dwell_sat_s = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Lamp input register: every decision works on last cycle's lamps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lamp_q <= 6'd0;
    end else begin
      lamp_q <= {mon.i_ns_red, mon.i_ns_yellow, mon.i_ns_green,
                 mon.i_ew_red, mon.i_ew_yellow, mon.i_ew_green};
    end
  end

  // Fault classification in RUN; branch order gives priority 1 > 2 > 3 > 4 > 5 (phase_q[0] marks yellow).
  always_comb begin
    run_code_s = FC_NONE;
    if (!legal_s) begin
      run_code_s = FC_COMBO;
    end else if (change_s && (lamp_ph_s != next_ph_s)) begin
      run_code_s = FC_ORDER;
    end else if (change_s && !first_q && !phase_q[0] && (dwell_p1_s < MIN_G_W)) begin
      run_code_s = FC_SHORT_G;
    end else if (change_s && !first_q && phase_q[0] && (dwell_p1_s < MIN_Y_W)) begin
      run_code_s = FC_SHORT_Y;
    end else if (phase_q[0] && (dwell_sat_s > MAX_Y_W)) begin
      run_code_s = FC_Y_TMO;
    end else begin
      run_code_s = FC_NONE;
    end
  end

  // State and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT;
      phase_q     <= 2'd0;
      vld_q       <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      dwell_q     <= {CNT_W{1'b0}};
      first_q     <= 1'b0;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
      cycle_cnt_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      vld_q       <= vld_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      dwell_q     <= dwell_d;
      first_q     <= first_d;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
      cycle_cnt_q <= cycle_cnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = legal_s ? ST_RUN : ST_INIT;
      ST_RUN:   state_d = (run_code_s != FC_NONE) ? ST_FAULT : ST_RUN;
      ST_FAULT: state_d = (mon.i_fault_clr && legal_s) ? ST_INIT : ST_FAULT;
      default:  state_d = ST_INIT;
    endcase
  end

  // Output next values; FAULT holds everything, including the dwell count.
  always_comb begin
    phase_d     = phase_q;
    vld_d       = vld_q;
    fault_d     = fault_q;
    code_d      = code_q;
    dwell_d     = dwell_q;
    first_d     = first_q;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
    cycle_cnt_d = cycle_cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (legal_s) begin
          phase_d = lamp_ph_s;
          vld_d   = 1'b1;
          dwell_d = {CNT_W{1'b0}};
          first_d = 1'b1;
        end else begin
          vld_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (run_code_s != FC_NONE) begin
          fault_d = 1'b1;
          code_d  = run_code_s;
          vld_d   = 1'b0;
        end else if (change_s) begin
          phase_d = lamp_ph_s;
          dwell_d = {CNT_W{1'b0}};
          first_d = 1'b0;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
          if (phase_q == PH_EW_Y) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
          end else begin
            cycle_cnt_d = cycle_cnt_q;
          end
`endif
        end else begin
          dwell_d = dwell_sat_s;
        end
      end
      ST_FAULT: begin
        if (mon.i_fault_clr && legal_s) begin
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end else begin
          fault_d = 1'b1;
        end
      end
      default: begin
        vld_d = 1'b0;
      end
    endcase
  end

  assign mon.o_phase       = phase_q;
  assign mon.o_phase_vld   = vld_q;
  assign mon.o_fault       = fault_q;
  assign mon.o_fault_code  = code_q;
  assign mon.o_force_flash = fault_q;
  assign mon.o_dwell       = dwell_q;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  assign mon.o_cycle_cnt   = cycle_cnt_q;
`endif

endmodule

// File: doc/traffic_monitor.md
Name: traffic_monitor

Overview:
- Lamp-side conflict monitor: the receiving end of the six lamp lines driven by traffic_light.
- Samples the lamps every clock, decodes them into a phase, and checks legal encoding, legal phase order, and minimum/maximum dwell times.
- On any violation it latches a fault code and asserts a force-flash request for the cabinet failsafe logic.

Parameters:
- CNT_W, 8, width of the dwell counter (saturating).
- MIN_GREEN, 16, minimum cycles a green phase must be held before leaving it.
- MIN_YELLOW, 3, minimum cycles a yellow phase must be held before leaving it.
- MAX_YELLOW, 8, maximum cycles a yellow phase may be held.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_ns_red / i_ns_yellow / i_ns_green  input  1 each  NS lamp lines
- i_ew_red / i_ew_yellow / i_ew_green  input  1 each  EW lamp lines
- i_fault_clr  input  1  single-cycle request to clear a latched fault
- o_phase  output  2  decoded phase: 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y
- o_phase_vld  output  1  o_phase is valid (monitor in RUN)
- o_fault  output  1  sticky fault flag
- o_fault_code  output  3  0 none, 1 illegal combo, 2 illegal transition, 3 short green, 4 short yellow, 5 yellow timeout
- o_force_flash  output  1  failsafe request, equal to o_fault
- o_dwell  output  CNT_W  cycles spent in the current phase

Behaviour:
- Reset (async assert, sync release): state INIT; all outputs 0; dwell counter 0.
- Lamps are registered once on entry, so every decision lands one cycle after the lamp change.
- Legal combos (all other lamp bits 0):
  - NS_G = ns_green and ew_red
  - NS_Y = ns_yellow and ew_red
  - EW_G = ew_green and ns_red
  - EW_Y = ew_yellow and ns_red
- Anything else, including all-off, is illegal.
- Legal order: NS_G->NS_Y->EW_G->EW_Y->NS_G. Holding the same phase is always legal.

States:
- INIT:
  - Wait for the first legal combo, then go to RUN with o_phase loaded, o_phase_vld=1, dwell=0.
  - Illegal combos in INIT are ignored; the monitor is not yet armed.
- RUN, each cycle:
  - Same phase: dwell += 1, saturating at 2^CNT_W-1.
  - Legal next phase: check the dwell of the phase being left, then load the new phase and set dwell=0.
  - Min-dwell checks are skipped on the first exit after INIT, because the entry time is unknown.
  - Leaving a green with dwell+1 < MIN_GREEN gives code 3.
  - Leaving a yellow with dwell+1 < MIN_YELLOW gives code 4.
  - In a yellow phase, dwell+1 > MAX_YELLOW gives code 5.
  - Any other phase change gives code 2. An illegal combo gives code 1.
- Fault entry: o_fault=1, o_force_flash=1, o_fault_code latched, o_phase_vld=0, go to FAULT.
- Priority when several faults occur in one cycle: 1 > 2 > 3 > 4 > 5.
- FAULT:
  - Outputs hold and o_dwell freezes.
  - i_fault_clr=1 together with a legal registered combo clears the fault (code 0), returns to INIT and re-arms.
  - i_fault_clr with an illegal combo is ignored.
- Clear and a new fault condition in the same cycle: the fault wins and the monitor stays in FAULT.
- Reset during FAULT returns to INIT and clears everything.
- MAX_YELLOW is checked against the saturated count. Legal parameter ranges: MIN_YELLOW ≤ MAX_YELLOW < 2^CNT_W.

Optional Feature:
- Macro: TRAFFIC_MON_CYCLE_CNT_EN.
- Defined:
  - Adds output o_cycle_cnt (16 bits), reset 0.
  - Increments on each legal, non-faulting EW_Y->NS_G transition; wraps 0xFFFF->0.
  - Holds in FAULT; cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then drive NS_G 20 cyc, NS_Y 4, EW_G 20, EW_Y 4, NS_G -> o_phase follows 0,1,2,3,0 with 1-cycle lag; o_fault=0; o_dwell resets to 0 on each change.
- In RUN, NS_G, then assert ns_green and ew_green together -> next cycle o_fault=1, o_fault_code=1, o_force_flash=1, o_phase_vld=0.
- After full legal NS_G, switch NS_G->EW_G directly -> o_fault_code=2.
- Second NS_G held 10 cyc, then NS_Y -> o_fault_code=3. Separately, EW_Y held 9 cyc -> code 5 on the cycle dwell+1 reaches 9.
- In FAULT, pulse i_fault_clr while lamps are all-off -> fault stays set. Pulse again with EW_G -> o_fault=0, state INIT, o_phase_vld=1 one cycle later.
- With TRAFFIC_MON_CYCLE_CNT_EN, run 3 full legal cycles -> o_cycle_cnt=3. Preload the counter to 0xFFFF via a forced cycle count -> wraps to 0. Assert i_rst_n=0 mid-FAULT -> all outputs 0 immediately.
